// File: rtl/eq2_selftest_ctrl.sv
// Built-in self-test sequencer for the 2-bit equality comparator.
// Walks every {a,b} vector, waits a settle time, checks aeqb and records errors and the first failure.
module eq2_selftest_ctrl #(
  parameter int W      = 2,
  parameter int SETTLE = 4,
  localparam int IW    = 2*W,
  localparam int CW    = 2*W+1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  input  logic          aeqb,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic          fail_valid,
  output logic [IW-1:0] fail_vec
);

  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic          mismatch;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_next = S_APPLY;
      S_APPLY:        state_next = S_WAIT;
      S_WAIT:         if (timer == '0) state_next = S_CHECK;
      S_CHECK:        state_next = (&idx) ? S_DONE : S_APPLY;
      default:        state_next = S_IDLE;
    endcase
  end

  assign mismatch = (aeqb != (a == b));

  // Operands come straight from idx, so they only move when idx does (entry to APPLY).
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      timer      <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx        <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        S_APPLY: timer <= TW'(SETTLE-1);
        S_WAIT:  if (timer != '0) timer <= timer - TW'(1);
        S_CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + CW'(1);
            if (!fail_valid) begin
              fail_vec   <= idx;
              fail_valid <= 1'b1;
            end
          end
          if (!(&idx)) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign a    = idx[IW-1:W];
  assign b    = idx[W-1:0];
  assign busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_eq2_selftest_ctrl.sv
// Self-checking bench for eq2_selftest_ctrl: a fault mask corrupts the comparator model per vector,
// and a reference computed from the mask predicts the error count and first failing vector.
module tb_eq2_selftest_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] a, b;
  logic       aeqb;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic       fail_valid;
  logic [3:0] fail_vec;

  logic [15:0] mask;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Comparator under test: correct result flipped on vectors selected by mask.
  assign aeqb = (a == b) ^ mask[{a, b}];

  eq2_selftest_ctrl #(.W(2), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .aeqb(aeqb),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_ab"}, {28'd0, a, b}, 32'd0);
    check({tag, "_err"}, {27'd0, err_cnt}, 32'd0);
    check({tag, "_fv"}, {31'd0, fail_valid}, 32'd0);
    check({tag, "_fvec"}, {28'd0, fail_vec}, 32'd0);
  endtask

  // Full run from IDLE or DONE; optionally pulses start again while busy (must be ignored).
  task automatic run(input logic [15:0] m, input bit mid_start, input string tag);
    int cyc, last, guard, exp_err, exp_first;
    logic [3:0] prev;
    exp_err = 0;
    exp_first = -1;
    for (int v = 0; v < 16; v++)
      if (m[v]) begin
        exp_err++;
        if (exp_first < 0) exp_first = v;
      end
    mask = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    check({tag, "_done0"}, {31'd0, done}, 32'd0);
    check({tag, "_ab0"}, {28'd0, a, b}, 32'd0);
    check({tag, "_clr"}, {26'd0, fail_valid, err_cnt}, 32'd0);
    cyc = 1;
    last = 1;
    guard = 0;
    prev = {a, b};
    while (!done && guard < 300) begin
      start = (mid_start && cyc == 20);
      @(negedge clk);
      guard++;
      if (busy && done) check({tag, "_busy_done"}, 32'd1, 32'd0);
      if (busy) begin
        cyc++;
        if ({a, b} !== prev) begin
          check({tag, "_ab_hold"}, cyc - last, 32'd6);
          check({tag, "_ab_step"}, {28'd0, a, b}, {28'd0, prev + 4'd1});
          prev = {a, b};
          last = cyc;
        end
      end
    end
    start = 1'b0;
    check({tag, "_cycles"}, cyc, 32'd96);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, "_err"}, {27'd0, err_cnt}, exp_err);
    check({tag, "_fv"}, {31'd0, fail_valid}, (exp_err != 0) ? 32'd1 : 32'd0);
    check({tag, "_fvec"}, {28'd0, fail_vec}, (exp_err != 0) ? exp_first : 32'd0);
  endtask

  initial begin
    logic [15:0] stuck1, stuck0;
    int guard;
    mask = '0;
    reset = 1'b1;
    start = 1'b0;
    for (int v = 0; v < 16; v++) begin
      stuck1[v] = (v[3:2] != v[1:0]);
      stuck0[v] = (v[3:2] == v[1:0]);
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);

    run(16'h0000, 1'b0, "good");
    run(stuck1, 1'b0, "stuck1");
    check("stuck1_err_const", {27'd0, err_cnt}, 32'd12);
    check("stuck1_fvec_const", {28'd0, fail_vec}, 32'd1);
    run(stuck0, 1'b0, "stuck0");
    run(16'hFFFF, 1'b0, "invert");
    run(16'h0000, 1'b0, "after_fail");

    // DONE holds its results while start stays low.
    repeat (5) @(negedge clk);
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_pass", {31'd0, pass}, 32'd1);

    run(stuck1, 1'b1, "mid_start");

    // Reset in WAIT of vector 5.
    mask = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    guard = 0;
    while ({a, b} !== 4'b0101 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reach_vec5", {28'd0, a, b}, 32'd5);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_reset_outputs("midrst");
    run(16'h0000, 1'b0, "post_rst");

    for (int i = 0; i < 4; i++) run(16'($urandom), 1'b0, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
